// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_reg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame shift counter: wraps every WIDTH increments and pulses done on the wrapping edge.
module shift_frame_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;
  logic             last;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (last) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / load) with frame counting.
// Define SHIFT_ROTATE_EN to add the rotate input, which recirculates the outgoing bit.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             fb_r, fb_l;
  logic             inc, clr;

`ifdef SHIFT_ROTATE_EN
  assign fb_r = rotate ? q_q[0]       : sin_r;
  assign fb_l = rotate ? q_q[WIDTH-1] : sin_l;
`else
  assign fb_r = sin_r;
  assign fb_l = sin_l;
`endif

  always_comb begin
    q_d = q_q;
    inc = 1'b0;
    clr = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d = {fb_r, q_q[WIDTH-1:1]};
          inc = 1'b1;
        end
        MODE_SHL: begin
          q_d = {q_q[WIDTH-2:0], fb_l};
          inc = 1'b1;
        end
        MODE_LOAD: begin
          q_d = pin;
          clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_frame_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .cnt   (shift_cnt),
    .done  (frame_done)
  );

  assign pout   = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=4) against an arithmetic reference model.
module tb_shift_reg_univ;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic         rotate = 1'b0;
  logic [W-1:0] pin = '0;
  logic [W-1:0] pout;
  logic         sout_r, sout_l;
  logic [1:0]   shift_cnt;
  logic         frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register value as an integer, shifts counted since frame start.
  int unsigned m_q = 0;
  int unsigned m_shifts = 0;
  int unsigned m_cnt = 0;
  bit          m_done = 0;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
`ifdef SHIFT_ROTATE_EN
    .rotate     (rotate),
`endif
    .pin        (pin),
    .pout       (pout),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_shifts = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_step(input bit e, input int md, input bit sr, input bit sl,
                            input int unsigned p, input bit rot);
    int unsigned fb;
    m_done = 0;
    if (e) begin
      if (md == 1) begin
        fb = rot ? (m_q % 2) : sr;
        m_q = (m_q / 2) + fb * (1 << (W - 1));
        m_shifts++;
        m_done = (m_shifts % W == 0);
      end else if (md == 2) begin
        fb = rot ? (m_q / (1 << (W - 1))) : sl;
        m_q = (m_q * 2 + fb) % (1 << W);
        m_shifts++;
        m_done = (m_shifts % W == 0);
      end else if (md == 3) begin
        m_q = p;
        m_shifts = 0;
      end
    end
    m_cnt = m_shifts % W;
  endtask

  // Drive one cycle's inputs, clock it, and advance the model.
  task automatic cycle(input bit e, input int md, input bit sr, input bit sl,
                       input int unsigned p, input bit rot);
    en = e; mode = 2'(md); sin_r = sr; sin_l = sl; pin = W'(p); rotate = rot;
    @(posedge clk);
    #1;
    model_step(e, md, sr, sl, p, rot);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if (pout !== 4'b0000 || shift_cnt !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: pout=%b cnt=%0d done=%b, want 0000/0/0",
               pout, shift_cnt, frame_done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    // Build a mid-frame state: cnt=2, q=1010.
    cycle(1, 3, 0, 0, 4'b0010, 0);
    cycle(1, 2, 0, 1, 0, 0);
    cycle(1, 2, 0, 0, 0, 0);
    n_tests++;
    if (pout !== 4'b1010 || shift_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_setup: pout=%b cnt=%0d, want 1010/2", pout, shift_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (pout !== 4'b0000 || shift_cnt !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: pout=%b cnt=%0d done=%b, want 0000/0/0",
               pout, shift_cnt, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load_shr();
    bit exp_sout [4] = '{1, 1, 0, 1};
    cycle(1, 3, 0, 0, 4'b1011, 0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (sout_r !== exp_sout[i]) begin
        n_fail++;
        $display("FAIL shr_sout[%0d]: got %b, want %b", i, sout_r, exp_sout[i]);
      end
      cycle(1, 1, 0, 1, 4'b1111, 0);
      n_tests++;
      if (frame_done !== (i == 3) || pout !== 4'(m_q)) begin
        n_fail++;
        $display("FAIL shr_step[%0d]: done=%b pout=%b, want %b/%b",
                 i, frame_done, pout, (i == 3), 4'(m_q));
      end
    end
    n_tests++;
    if (pout !== 4'b0000) begin
      n_fail++;
      $display("FAIL shr_final: pout=%b, want 0000", pout);
    end
  endtask

  task automatic test_shl_frames();
    bit bits [4] = '{1, 0, 0, 1};
    cycle(1, 3, 0, 0, 4'b0110, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 2, 1, bits[i % 4], 0, 0);
      n_tests++;
      if (frame_done !== (i == 3 || i == 7) || pout !== 4'(m_q) || shift_cnt !== 2'(m_cnt)) begin
        n_fail++;
        $display("FAIL shl_frames[%0d]: done=%b pout=%b cnt=%0d, want %b/%b/%0d",
                 i, frame_done, pout, shift_cnt, (i == 3 || i == 7), 4'(m_q), m_cnt);
      end
      if (i == 3) begin
        n_tests++;
        if (pout !== 4'b1001) begin
          n_fail++;
          $display("FAIL shl_word: pout=%b, want 1001", pout);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] held;
    cycle(1, 3, 0, 0, 4'b0110, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    held = pout;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 1, 4'b1111, 0);
      n_tests++;
      if (shift_cnt !== 2'd2 || pout !== held || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_freeze[%0d]: cnt=%0d pout=%b done=%b, want 2/%b/0",
                 i, shift_cnt, pout, frame_done, held);
      end
    end
    cycle(1, 1, 1, 0, 0, 0);
    n_tests++;
    if (frame_done !== 1'b0 || shift_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL enable_resume3: done=%b cnt=%0d, want 0/3", frame_done, shift_cnt);
    end
    cycle(1, 1, 0, 0, 0, 0);
    n_tests++;
    if (frame_done !== 1'b1 || shift_cnt !== 2'd0 || pout !== 4'(m_q)) begin
      n_fail++;
      $display("FAIL enable_complete: done=%b cnt=%0d pout=%b, want 1/0/%b",
               frame_done, shift_cnt, pout, 4'(m_q));
    end
    cycle(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_pulse_width: done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_load_midframe();
    cycle(1, 3, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) cycle(1, 2, 0, 1, 0, 0);
    n_tests++;
    if (shift_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL midload_setup: cnt=%0d, want 3", shift_cnt);
    end
    cycle(1, 3, 1, 1, 4'b1100, 0);
    n_tests++;
    if (pout !== 4'b1100 || shift_cnt !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midload: pout=%b cnt=%0d done=%b, want 1100/0/0",
               pout, shift_cnt, frame_done);
    end
  endtask

`ifdef SHIFT_ROTATE_EN
  task automatic test_rotate();
    logic [W-1:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cycle(1, 3, 0, 0, 4'b0001, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 2, 0, 0, 0, 1);
      n_tests++;
      if (pout !== exp_q[i] || frame_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL rotate[%0d]: pout=%b done=%b, want %b/%b",
                 i, pout, frame_done, exp_q[i], (i == 3));
      end
    end
  endtask
`endif

  task automatic test_random();
    bit          e, sr, sl, rot;
    int          md;
    int unsigned p;
    for (int i = 0; i < 300; i++) begin
      e   = ($urandom_range(0, 9) != 0);
      md  = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
      sr  = 1'($urandom);
      sl  = 1'($urandom);
      p   = $urandom_range(0, 15);
`ifdef SHIFT_ROTATE_EN
      rot = 1'($urandom);
`else
      rot = 0;
`endif
      cycle(e, md, sr, sl, p, rot);
      n_tests++;
      if (pout !== 4'(m_q) || shift_cnt !== 2'(m_cnt) || frame_done !== m_done ||
          sout_r !== 1'(m_q % 2) || sout_l !== 1'(m_q / 8)) begin
        n_fail++;
        $display("FAIL random[%0d]: pout=%b cnt=%0d done=%b sr=%b sl=%b, want %b/%0d/%b",
                 i, pout, shift_cnt, frame_done, sout_r, sout_l, 4'(m_q), m_cnt, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shr();
    test_shl_frames();
    test_enable();
    test_load_midframe();
`ifdef SHIFT_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
